// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: RAW-hazard stall, redirect flush and stall-cycle counter for the 6-stage RV32I pipeline
// Ports: clk_in, rst_n_in (synchronous, active-low); id_* describe the instruction held in ID;
//   ex_redirect_in marks a taken branch/jump resolved in EX; stall_out holds PC/ID,
//   bubble_ex_out loads a NOP into EX, flush_id_out loads a NOP into ID;
//   stall_cycles_out is a saturating count of stalled cycles.
// Macro RISCV_RF_WRITE_THROUGH_EN: regfile forwards same-cycle writes, so the WB2 entry is not matched.
module riscv_hazard_ctrl #(
  parameter int SB_DEPTH  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 id_valid_in,
  input  logic [4:0]           id_rs1_in,
  input  logic [4:0]           id_rs2_in,
  input  logic                 id_uses_rs1_in,
  input  logic                 id_uses_rs2_in,
  input  logic [4:0]           id_rd_in,
  input  logic                 id_werf_in,
  input  logic                 ex_redirect_in,
  output logic                 stall_out,
  output logic                 bubble_ex_out,
  output logic                 flush_id_out,
  output logic [CNT_WIDTH-1:0] stall_cycles_out
);
`ifdef RISCV_RF_WRITE_THROUGH_EN
  localparam int MATCH_N = SB_DEPTH - 1;
`else
  localparam int MATCH_N = SB_DEPTH;
`endif
  logic [SB_DEPTH-1:0] sb_v;
  logic [4:0]          sb_rd [SB_DEPTH];
  logic                m1, m2, hazard, push;
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < MATCH_N; i++) begin
      m1 = m1 | (sb_v[i] && sb_rd[i] == id_rs1_in);
      m2 = m2 | (sb_v[i] && sb_rd[i] == id_rs2_in);
    end
  end
  // x0 is excluded here as well as at capture, so a stale x0 entry can never stall.
  assign hazard = rst_n_in && id_valid_in &&
                  ((id_uses_rs1_in && id_rs1_in != 5'd0 && m1) ||
                   (id_uses_rs2_in && id_rs2_in != 5'd0 && m2));
  assign stall_out     = hazard && !ex_redirect_in;
  assign bubble_ex_out = rst_n_in && (stall_out || ex_redirect_in);
  assign flush_id_out  = rst_n_in && ex_redirect_in;
  assign push = id_valid_in && id_werf_in && id_rd_in != 5'd0 && !stall_out && !ex_redirect_in;
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sb_v <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= 5'd0;
      stall_cycles_out <= '0;
    end else begin
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_v[0]  <= push;
      sb_rd[0] <= push ? id_rd_in : 5'd0;
      if (stall_out && stall_cycles_out != '1) stall_cycles_out <= stall_cycles_out + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: scoreboard bench for riscv_hazard_ctrl (CNT_WIDTH=4 build)
module tb_riscv_hazard_ctrl;
  localparam int SD = 4;
  localparam int CW = 4;
`ifdef RISCV_RF_WRITE_THROUGH_EN
  localparam int WT = 1;
`else
  localparam int WT = 0;
`endif
  localparam int MN = SD - WT;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct packed {
    logic v, u1, u2, w;
    logic [4:0] rs1, rs2, rd;
  } ins_t;
  typedef struct packed {
    logic st, bub, fl;
    logic [CW-1:0] cnt;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_n_in, id_valid_in, id_uses_rs1_in, id_uses_rs2_in, id_werf_in, ex_redirect_in;
  logic [4:0] id_rs1_in, id_rs2_in, id_rd_in;
  logic stall_out, bubble_ex_out, flush_id_out;
  logic [CW-1:0] stall_cycles_out;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  logic mv [SD];
  logic [4:0] mrd [SD];
  int mcnt = 0;
  logic [CW-1:0] last_cnt;
  riscv_hazard_ctrl #(.SB_DEPTH(SD), .CNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .id_valid_in(id_valid_in),
    .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in), .id_uses_rs1_in(id_uses_rs1_in),
    .id_uses_rs2_in(id_uses_rs2_in), .id_rd_in(id_rd_in), .id_werf_in(id_werf_in),
    .ex_redirect_in(ex_redirect_in), .stall_out(stall_out), .bubble_ex_out(bubble_ex_out),
    .flush_id_out(flush_id_out), .stall_cycles_out(stall_cycles_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic ins_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    ins_t i;
    i.v = 1'b1; i.w = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    return i;
  endfunction
  // one clock: drive at negedge, predict, compare mid-low-phase, advance model at posedge
  task automatic cyc(input ins_t i, input logic red, input logic rn, output logic est, output logic ost);
    logic h1, h2, hz;
    exp_t e, g;
    rst_n_in = rn; id_valid_in = i.v; id_rs1_in = i.rs1; id_rs2_in = i.rs2;
    id_uses_rs1_in = i.u1; id_uses_rs2_in = i.u2; id_rd_in = i.rd; id_werf_in = i.w;
    ex_redirect_in = red;
    h1 = 1'b0; h2 = 1'b0;
    for (int k = 0; k < MN; k++) begin
      if (mv[k] && mrd[k] == i.rs1) h1 = 1'b1;
      if (mv[k] && mrd[k] == i.rs2) h2 = 1'b1;
    end
    hz = rn && i.v && ((i.u1 && i.rs1 != 0 && h1) || (i.u2 && i.rs2 != 0 && h2));
    e.st = hz && !red;
    e.bub = rn && (e.st || red);
    e.fl = rn && red;
    e.cnt = mcnt[CW-1:0];
    q.push_back(e);
    #2;
    g = q.pop_front();
    check("stall", stall_out, g.st);
    check("bubble", bubble_ex_out, g.bub);
    check("flush", flush_id_out, g.fl);
    check("cnt", stall_cycles_out, g.cnt);
    est = e.st;
    ost = stall_out;
    last_cnt = stall_cycles_out;
    @(posedge clk_in);
    if (!rn) begin
      for (int k = 0; k < SD; k++) begin mv[k] = 1'b0; mrd[k] = 5'd0; end
      mcnt = 0;
    end else begin
      for (int k = SD - 1; k > 0; k--) begin mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; end
      mv[0] = i.v && i.w && i.rd != 0 && !e.st && !red;
      mrd[0] = mv[0] ? i.rd : 5'd0;
      if (e.st && mcnt != CMAX) mcnt++;
    end
    @(negedge clk_in);
  endtask
  // present one instruction until it leaves ID; returns observed stall cycles
  task automatic issue(input ins_t i, output int nst);
    logic est, ost;
    int k;
    nst = 0;
    for (k = 0; k < 12; k++) begin
      cyc(i, 1'b0, 1'b1, est, ost);
      if (ost) nst++;
      if (!est) break;
    end
    if (k == 12) check("stall_bound", 32'd1, 32'd0);
  endtask
  task automatic drain();
    int n;
    for (int k = 0; k < SD + 1; k++) issue(mk(0, 0, 0, 0, 0), n);
  endtask
  initial begin
    ins_t nop, addi5, add655;
    int n;
    logic est, ost;
    nop = mk(0, 0, 0, 0, 0);
    addi5 = mk(5, 0, 1, 0, 0);
    add655 = mk(6, 5, 1, 5, 1);
    for (int k = 0; k < SD; k++) begin mv[k] = 1'b0; mrd[k] = 5'd0; end
    rst_n_in = 1'b0; id_valid_in = 1'b0; id_rs1_in = 0; id_rs2_in = 0; id_uses_rs1_in = 0;
    id_uses_rs2_in = 0; id_rd_in = 0; id_werf_in = 0; ex_redirect_in = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    cyc(add655, 1'b0, 1'b0, est, ost);
    check("rst_cnt", last_cnt, 0);
    // back-to-back dependency, rs1==rs2 counted once
    issue(addi5, n);
    issue(add655, n);
    check("b2b_stalls", n, SD - WT);
    check("b2b_cnt", mcnt, SD - WT);
    drain();
    // distance 3 dependency, then an independent instruction
    issue(addi5, n);
    issue(nop, n);
    issue(nop, n);
    issue(mk(6, 5, 1, 0, 1), n);
    check("dist3_stalls", n, SD - 3 + 1 - WT);
    issue(mk(7, 1, 1, 2, 1), n);
    check("indep_stalls", n, 0);
    drain();
    // x0 is never tracked
    issue(mk(0, 0, 1, 0, 0), n);
    issue(mk(6, 0, 1, 0, 1), n);
    check("x0_stalls", n, 0);
    drain();
    // redirect discards the dependent wrong-path instruction
    issue(addi5, n);
    cyc(add655, 1'b1, 1'b1, est, ost);
    check("redir_stall", ost, 0);
    issue(mk(8, 6, 1, 0, 0), n);
    check("redir_no_track", n, 0);
    drain();
    // reset during the second stall cycle
    issue(addi5, n);
    cyc(add655, 1'b0, 1'b1, est, ost);
    cyc(add655, 1'b0, 1'b0, est, ost);
    check("midrst_stall", ost, 0);
    cyc(add655, 1'b0, 1'b1, est, ost);
    check("postrst_stall", ost, 0);
    check("postrst_cnt", last_cnt, 0);
    drain();
    // saturation of the stall counter
    for (int r = 0; r < 8; r++) begin
      issue(addi5, n);
      issue(add655, n);
    end
    drain();
    check("sat_cnt", last_cnt, CMAX);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
